// File: rtl/top_chip_intr_ctrl.sv
// Prioritised interrupt controller: per-source edge/level capture, pending/active tracking,
// claim/complete handshake with edge re-pend, and fixed lowest-index-wins arbitration.
module top_chip_intr_ctrl #(
  parameter int                NumSrc  = 32,
  parameter logic [NumSrc-1:0] EdgeSrc = '0,
  parameter int                IdW     = $clog2(NumSrc)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumSrc-1:0] src_i,
  input  logic [NumSrc-1:0] enable_i,
  input  logic [NumSrc-1:0] clear_i,
  input  logic              claim_i,
  input  logic              complete_i,
  input  logic [IdW-1:0]    complete_id_i,
  output logic              irq_o,
  output logic [IdW-1:0]    irq_id_o,
  output logic [NumSrc-1:0] pending_o,
  output logic [NumSrc-1:0] active_o
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPending = 2'd1,
    StActive  = 2'd2
  } state_e;

  logic [NumSrc-1:0] src_q;
  logic [NumSrc-1:0] edge_det;
  logic [NumSrc-1:0] pend_vec;
  logic [NumSrc-1:0] act_vec;
  logic [NumSrc-1:0] claim_hit;
  logic [NumSrc-1:0] complete_hit;
  logic              irq_int;
  logic [IdW-1:0]    irq_id_int;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q <= '0;
    end else begin
      src_q <= src_i;
    end
  end

  assign edge_det = src_i & ~src_q;

  // Descending scan so the lowest enabled pending index is the last one written.
  always_comb begin
    irq_int    = 1'b0;
    irq_id_int = '0;
    for (int k = NumSrc - 1; k >= 0; k--) begin
      if (pend_vec[k] && enable_i[k]) begin
        irq_int    = 1'b1;
        irq_id_int = IdW'(k);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NumSrc; gi++) begin : g_src
      state_e state_q, state_d;
      logic   repend_q, repend_d;
      logic   trig;

      assign trig              = EdgeSrc[gi] ? edge_det[gi] : src_i[gi];
      assign claim_hit[gi]     = claim_i & irq_int & (irq_id_int == IdW'(gi));
      // Out-of-range IDs can never match any source index, so they fall through harmlessly.
      assign complete_hit[gi]  = complete_i & (complete_id_i == IdW'(gi));
      assign pend_vec[gi]      = (state_q == StPending);
      assign act_vec[gi]       = (state_q == StActive);

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          state_q  <= StIdle;
          repend_q <= 1'b0;
        end else begin
          state_q  <= state_d;
          repend_q <= repend_d;
        end
      end

      always_comb begin
        state_d  = state_q;
        repend_d = repend_q;
        unique case (state_q)
          StIdle: begin
            if (trig) begin
              state_d = StPending;
            end
          end
          StPending: begin
            if (claim_hit[gi]) begin
              state_d = StActive;
            end else if (clear_i[gi] || (!EdgeSrc[gi] && !src_i[gi])) begin
              state_d = StIdle;
            end
          end
          StActive: begin
            if (complete_hit[gi]) begin
              repend_d = 1'b0;
              if (EdgeSrc[gi] ? (repend_q | edge_det[gi]) : src_i[gi]) begin
                state_d = StPending;
              end else begin
                state_d = StIdle;
              end
            end else if (EdgeSrc[gi]) begin
              if (edge_det[gi]) begin
                repend_d = 1'b1;
              end else if (clear_i[gi]) begin
                repend_d = 1'b0;
              end
            end
          end
          default: begin
            state_d  = StIdle;
            repend_d = 1'b0;
          end
        endcase
      end
    end
  endgenerate

  assign irq_o     = irq_int;
  assign irq_id_o  = irq_id_int;
  assign pending_o = pend_vec;
  assign active_o  = act_vec;

endmodule

// File: tb/tb_top_chip_intr_ctrl.sv
// Bench for top_chip_intr_ctrl: directed scenarios plus random traffic, all checked against
// a per-source behavioural model of the interrupt rules.
module tb_top_chip_intr_ctrl;

  localparam int NS = 20;
  localparam int IW = $clog2(NS);
  localparam logic [NS-1:0] EDGE = 20'hA_5418;  // edge sources: 3,4,10,12,14,17,19

  logic          clk;
  logic          rst_i;
  logic [NS-1:0] src, en, clr;
  logic          claim, cmp;
  logic [IW-1:0] cmp_id;
  logic          irq_o;
  logic [IW-1:0] irq_id_o;
  logic [NS-1:0] pending_o, active_o;

  top_chip_intr_ctrl #(.NumSrc(NS), .EdgeSrc(EDGE)) dut (
    .clk_i(clk), .rst_i(rst_i), .src_i(src), .enable_i(en), .clear_i(clr),
    .claim_i(claim), .complete_i(cmp), .complete_id_i(cmp_id),
    .irq_o(irq_o), .irq_id_o(irq_id_o), .pending_o(pending_o), .active_o(active_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: 0 = idle, 1 = pending, 2 = active
  int  st[NS];
  bit  rp[NS];
  bit  sq[NS];
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NS; k++) begin
      st[k] = 0; rp[k] = 0; sq[k] = 0;
    end
  endfunction

  function automatic int model_winner();
    for (int k = 0; k < NS; k++)
      if (st[k] == 1 && en[k]) return k;
    return -1;
  endfunction

  function automatic void model_step();
    int  w;
    bit  e;
    w = model_winner();
    for (int k = 0; k < NS; k++) begin
      e = src[k] && !sq[k];
      case (st[k])
        0: if (EDGE[k] ? e : src[k]) st[k] = 1;
        1: begin
          if (claim && w == k) st[k] = 2;
          else if (clr[k] || (!EDGE[k] && !src[k])) st[k] = 0;
        end
        default: begin
          if (cmp && int'(cmp_id) == k) begin
            if (EDGE[k]) st[k] = (rp[k] || e) ? 1 : 0;
            else         st[k] = src[k] ? 1 : 0;
            rp[k] = 0;
          end else if (EDGE[k]) begin
            if (e) rp[k] = 1;
            else if (clr[k]) rp[k] = 0;
          end
        end
      endcase
      sq[k] = src[k];
    end
  endfunction

  task automatic check_all(input string tag);
    logic [NS-1:0] p, a;
    int w;
    for (int k = 0; k < NS; k++) begin
      p[k] = (st[k] == 1);
      a[k] = (st[k] == 2);
    end
    w = model_winner();
    chk({tag, ".pending"}, 64'(pending_o), 64'(p));
    chk({tag, ".active"},  64'(active_o),  64'(a));
    chk({tag, ".irq"},     64'(irq_o),     64'(w >= 0));
    chk({tag, ".irq_id"},  64'(irq_id_o),  (w >= 0) ? 64'(w) : 64'd0);
  endtask

  // Inputs are already driven; clock once, advance the model, then compare.
  task automatic step(input string tag, input bit verbose);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
    if (verbose)
      $display("%s: src=%05h clr=%05h claim=%0b cmp=%0b id=%0d -> irq=%0b id=%0d pend=%05h act=%05h",
               tag, src, clr, claim, cmp, cmp_id, irq_o, irq_id_o, pending_o, active_o);
    clr = '0; claim = 1'b0; cmp = 1'b0;
  endtask

  task automatic do_claim(input string tag);
    claim = 1'b1; step(tag, 1'b1);
  endtask

  task automatic do_complete(input string tag, input int id);
    cmp = 1'b1; cmp_id = IW'(id); step(tag, 1'b1);
  endtask

  initial begin
    int v;
    rst_i = 1'b1; src = '0; en = '1; clr = '0; claim = 0; cmp = 0; cmp_id = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.irq", 64'(irq_o), 64'd0);
    chk("reset.irq_id", 64'(irq_id_o), 64'd0);
    chk("reset.pending", 64'(pending_o), 64'd0);
    chk("reset.active", 64'(active_o), 64'd0);
    rst_i = 1'b0;

    // Edge source 3: pulse, claim, complete
    src[3] = 1'b1; step("e3_pulse", 1'b1);
    chk("e3_id", 64'(irq_id_o), 64'd3);
    src[3] = 1'b0; do_claim("e3_claim");
    chk("e3_act", 64'(active_o[3]), 64'd1);
    chk("e3_irq_low", 64'(irq_o), 64'd0);
    do_complete("e3_done", 3);
    chk("e3_idle", 64'(pending_o[3] | active_o[3]), 64'd0);

    // Level source 5: complete while still high re-pends, dropping the line clears
    src[5] = 1'b1; step("l5_high", 1'b1);
    do_claim("l5_claim");
    do_complete("l5_done_high", 5);
    chk("l5_repend_id", 64'(irq_id_o), 64'd5);
    src[5] = 1'b0; step("l5_drop", 1'b1);
    chk("l5_drop_irq", 64'(irq_o), 64'd0);

    // Priority between 2 and 7, then masking of 2
    src[2] = 1'b1; src[7] = 1'b1; step("p27", 1'b1);
    chk("p27_id", 64'(irq_id_o), 64'd2);
    do_claim("p27_claim2");
    chk("p27_next", 64'(irq_id_o), 64'd7);
    src[2] = 1'b0; do_complete("p27_done2", 2);
    src[7] = 1'b0; step("p27_drop", 1'b1);
    en[2] = 1'b0; src[2] = 1'b1; src[7] = 1'b1; step("mask2", 1'b1);
    chk("mask2_id", 64'(irq_id_o), 64'd7);
    chk("mask2_pend", 64'(pending_o[2]), 64'd1);
    en[2] = 1'b1; src[7] = 1'b0; step("unmask2", 1'b1);
    chk("unmask2_id", 64'(irq_id_o), 64'd2);
    src[2] = 1'b0; step("drop2", 1'b1);

    // Edge source 4: second pulse while active re-pends; clear cancels it
    src[4] = 1'b1; step("e4_pulse", 1'b1);
    src[4] = 1'b0; do_claim("e4_claim");
    src[4] = 1'b1; step("e4_pulse2", 1'b1);
    src[4] = 1'b0; do_complete("e4_done", 4);
    chk("e4_repend", 64'(pending_o[4]), 64'd1);
    do_claim("e4_claim2");
    src[4] = 1'b1; step("e4_pulse3", 1'b1);
    src[4] = 1'b0; clr[4] = 1'b1; step("e4_clear", 1'b1);
    do_complete("e4_done2", 4);
    chk("e4_idle", 64'(pending_o[4] | active_o[4]), 64'd0);

    // Ignored completes and claims
    src[4] = 1'b1; step("e4_pulse4", 1'b1);
    src[4] = 1'b0; do_claim("e4_claim3");
    do_complete("bad_id9", 9);
    do_complete("bad_idNS", NS);
    chk("bad_id_act", 64'(active_o[4]), 64'd1);
    do_claim("claim_noirq");
    do_complete("e4_done3", 4);

    // Claim and clear together, then asynchronous reset while active
    src[3] = 1'b1; step("e3b_pulse", 1'b1);
    src[3] = 1'b0; claim = 1'b1; clr[3] = 1'b1; step("claim_clr", 1'b1);
    chk("claim_clr_act", 64'(active_o[3]), 64'd1);
    rst_i = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    rst_i = 1'b0;

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < NS; k++) begin
        if ($urandom_range(0, 5) == 0) src[k] = ~src[k];
        clr[k] = ($urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 31) == 0) en = NS'($urandom);
      claim = ($urandom_range(0, 2) == 0);
      cmp   = ($urandom_range(0, 2) == 0);
      v = -1;
      for (int k = 0; k < NS; k++) if (st[k] == 2 && v < 0 && $urandom_range(0, 1) == 1) v = k;
      cmp_id = (v >= 0) ? IW'(v) : IW'($urandom_range(0, 31));
      step("rand", 1'b0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
